classified_result_sorter: RTL

- Downstream consumer of the NPU classification stream: captures each 66-bit classified entry ({class[1:0], data[63:0]}) plus its inference-memory address while the NPU reports running.
- When the NPU signals off, drains the captured entries on a valid/ready stream grouped by class (0,1,2,3), preserving arrival order within each class.
- Feeds the sorted-packet egress path.

---
 rtl/classified_result_sorter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/classified_result_sorter.sv
// classified_result_sorter
//   Captures classified NPU entries ({class, data} plus inference-memory address) while the NPU
//   runs. When npu_on falls, it drains the captured entries on a valid/ready stream grouped by
//   class (0..3). Arrival order is preserved within each class.
//
// Ports
//   clk, reset             system clock, asynchronous active-high reset
//   classified_data_in     {class[1:0], data[63:0]} from the NPU side
//   memory_address_in      inference-memory address of the current entry
//   valid_in               entry strobe, one capture per high cycle
//   npu_on                 high while classifying; a falling edge starts the sort
//   sorted_data_out/_class_out/_addr_out, sorted_valid, sorted_rdy   output stream
//   sort_busy              high while scanning or emitting
//   sort_done              one-cycle pulse when draining completes
//   overflow               sticky flag; an entry was dropped (cleared only by reset)
//   entry_count            entries currently held
module classified_result_sorter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CLASS_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned NUM_ENTRIES = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CLASS_WIDTH+DATA_WIDTH-1:0] classified_data_in,
  input  logic [ADDR_WIDTH-1:0]             memory_address_in,
  input  logic                              valid_in,
  input  logic                              npu_on,
  output logic [DATA_WIDTH-1:0]             sorted_data_out,
  output logic [CLASS_WIDTH-1:0]            sorted_class_out,
  output logic [ADDR_WIDTH-1:0]             sorted_addr_out,
  output logic                              sorted_valid,
  input  logic                              sorted_rdy,
  output logic                              sort_busy,
  output logic                              sort_done,
  output logic                              overflow,
  output logic [3:0]                        entry_count
);

  localparam logic [3:0] Full = 4'(NUM_ENTRIES);

  typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             ptr_q, ptr_d;
  logic [CLASS_WIDTH-1:0] cls_q, cls_d;
  logic [3:0]             count_q;
  logic                   npu_on_q;
  logic                   fall;
  logic                   capture;
  logic                   drop;
  logic                   load;
  logic [3:0]             ptr_idx;

  logic [DATA_WIDTH-1:0]  buf_data [NUM_ENTRIES];
  logic [CLASS_WIDTH-1:0] buf_cls  [NUM_ENTRIES];
  logic [ADDR_WIDTH-1:0]  buf_addr [NUM_ENTRIES];

  assign fall = npu_on_q & ~npu_on;

  // New entries are only accepted while idle and not full; anything else with npu_on high is lost.
  assign capture = valid_in & npu_on & (state_q == StIdle) & (count_q != Full);
  assign drop    = valid_in & npu_on & ((state_q != StIdle) | (count_q == Full));

  // ptr can legitimately reach NUM_ENTRIES (end-of-pass marker); keep the read index in range.
  assign ptr_idx = (ptr_q < Full) ? ptr_q : 4'd0;

  // Capture buffer has no reset: contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_data[count_q] <= classified_data_in[DATA_WIDTH-1:0];
      buf_cls[count_q]  <= classified_data_in[DATA_WIDTH +: CLASS_WIDTH];
      buf_addr[count_q] <= memory_address_in;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      ptr_q            <= '0;
      cls_q            <= '0;
      count_q          <= '0;
      npu_on_q         <= 1'b0;
      overflow         <= 1'b0;
      sorted_valid     <= 1'b0;
      sorted_data_out  <= '0;
      sorted_class_out <= '0;
      sorted_addr_out  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cls_q    <= cls_d;
      npu_on_q <= npu_on;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (state_q == StDone) begin
        count_q <= '0;
      end else if (capture) begin
        count_q <= count_q + 4'd1;
      end
      if (load) begin
        sorted_valid     <= 1'b1;
        sorted_data_out  <= buf_data[ptr_idx];
        sorted_class_out <= buf_cls[ptr_idx];
        sorted_addr_out  <= buf_addr[ptr_idx];
      end else if ((state_q == StEmit) && sorted_rdy) begin
        sorted_valid <= 1'b0;
      end
    end
  end

  // Next-state logic: one pass over the buffer per class, emitting matches in index order.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cls_d   = cls_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (fall) begin
          if (count_q == 4'd0) begin
            state_d = StDone;
          end else begin
            state_d = StScan;
            ptr_d   = '0;
            cls_d   = '0;
          end
        end
      end
      StScan: begin
        if (ptr_q == count_q) begin
          if (cls_q == '1) begin
            state_d = StDone;
          end else begin
            cls_d = cls_q + 1'b1;
            ptr_d = '0;
          end
        end else if (buf_cls[ptr_idx] == cls_q) begin
          load    = 1'b1;
          state_d = StEmit;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      StEmit: begin
        if (sorted_rdy) begin
          ptr_d   = ptr_q + 4'd1;
          state_d = StScan;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs.
  always_comb begin
    sort_busy   = (state_q == StScan) || (state_q == StEmit);
    sort_done   = (state_q == StDone);
    entry_count = count_q;
  end

endmodule
